// File: rtl/l1_tag_pkg.sv
// l1_tag_pkg: shared geometry, FSM states and address field helpers for the L1 tag controller
package l1_tag_pkg;
  localparam int ADDR_W  = 32;
  localparam int OFF_W   = 6;
  localparam int IDX_W   = 8;
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int ENTRY_W = TAG_W + 1;
  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP} state_e;
  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W+:IDX_W];
  endfunction
  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1-:TAG_W];
  endfunction
endpackage

// File: rtl/l1_tag_ctrl_if.sv
// l1_tag_ctrl_if: request/response and line-fill handshakes of the L1 tag controller
interface l1_tag_ctrl_if;
  import l1_tag_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic [ADDR_W-1:0] resp_addr;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  modport master (
    output req_valid, req_addr, mem_req_ready, mem_resp_valid,
    input  req_ready, resp_valid, resp_hit, resp_addr, mem_req_valid, mem_req_addr
  );
  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_resp_valid,
    output req_ready, resp_valid, resp_hit, resp_addr, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/l1_tag_stats.sv
// l1_tag_stats: saturating hit/miss counters, cleared by rst or clr
module l1_tag_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc_hit,
  input  logic        inc_miss,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (clr) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (inc_hit && !(&hit_q)) hit_q <= hit_q + 32'd1;
      if (inc_miss && !(&miss_q)) miss_q <= miss_q + 32'd1;
    end
  end
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
endmodule

// File: rtl/l1_tag_ctrl.sv
// l1_tag_ctrl: tag lookup, one-line refill and invalidate sweep over a 1R1W tag SRAM
// Optional L1_TAG_STATS_EN adds saturating hit_count/miss_count outputs.
module l1_tag_ctrl #(
  parameter int ADDR_W = l1_tag_pkg::ADDR_W,
  parameter int OFF_W  = l1_tag_pkg::OFF_W,
  parameter int IDX_W  = l1_tag_pkg::IDX_W,
  parameter int TAG_W  = l1_tag_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  l1_tag_ctrl_if.slave     bus,
  input  logic             flush,
  output logic             tag_csb0,
  output logic [IDX_W-1:0] tag_addr0,
  output logic [TAG_W:0]   tag_din0,
  output logic             tag_csb1,
  output logic [IDX_W-1:0] tag_addr1,
  input  logic [TAG_W:0]   tag_dout1
`ifdef L1_TAG_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);
  import l1_tag_pkg::*;
  state_e            state_q, state_d;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q, resp_addr_q, mem_req_addr_q;
  logic              flush_pend_q, flush_pend_d, accept, lookup_hit;
  logic              req_ready_q, resp_valid_q, resp_hit_q, mem_req_valid_q;
  logic              csb0_q;
  logic [IDX_W-1:0]  addr0_q;
  logic [TAG_W:0]    din0_q;
  always_comb begin
    accept       = bus.req_valid && req_ready_q;
    lookup_hit   = tag_dout1[TAG_W] && tag_dout1[TAG_W-1:0] == tag_of(addr_q);
    flush_pend_d = (state_q == INIT || (state_q == IDLE && flush_pend_q)) ? 1'b0 : flush_pend_q || flush;
    state_d      = state_q;
    case (state_q)
      INIT:      state_d = cnt_q == 8'hFF ? IDLE : INIT;
      IDLE:      state_d = flush_pend_q ? INIT : accept ? LOOKUP : IDLE;
      LOOKUP:    state_d = lookup_hit ? RESP : MISS_REQ;
      MISS_REQ:  state_d = bus.mem_req_ready ? MISS_WAIT : MISS_REQ;
      MISS_WAIT: state_d = bus.mem_resp_valid ? FILL : MISS_WAIT;
      FILL:      state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = INIT;
    endcase
  end
  // Write-port outputs lag the state by one cycle, so req_ready stays low until the last sweep write has retired
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= INIT;
      cnt_q           <= '0;
      addr_q          <= '0;
      flush_pend_q    <= 1'b0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_addr_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      csb0_q          <= 1'b1;
      addr0_q         <= '0;
      din0_q          <= '0;
    end else begin
      state_q         <= state_d;
      flush_pend_q    <= flush_pend_d;
      cnt_q           <= state_q == INIT ? cnt_q + 8'd1 : 8'd0;
      if (accept) addr_q <= bus.req_addr;
      if (state_q == LOOKUP) resp_hit_q <= lookup_hit;
      if (state_q == LOOKUP && !lookup_hit) mem_req_addr_q <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      if (state_q == RESP) resp_addr_q <= addr_q;
      req_ready_q     <= state_d == IDLE && state_q != INIT && !flush_pend_d;
      resp_valid_q    <= state_q == RESP;
      mem_req_valid_q <= state_d == MISS_REQ;
      csb0_q          <= !(state_q == INIT || state_q == FILL);
      addr0_q         <= state_q == FILL ? idx_of(addr_q) : cnt_q;
      din0_q          <= state_q == FILL ? {1'b1, tag_of(addr_q)} : '0;
    end
  end
  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_hit      = resp_hit_q;
  assign bus.resp_addr     = resp_addr_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign tag_csb0          = csb0_q;
  assign tag_addr0         = addr0_q;
  assign tag_din0          = din0_q;
  assign tag_csb1          = !accept;
  assign tag_addr1         = req_ready_q ? idx_of(bus.req_addr) : '0;
`ifdef L1_TAG_STATS_EN
  l1_tag_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q == IDLE && flush_pend_q),
    .inc_hit    (resp_valid_q && resp_hit_q),
    .inc_miss   (resp_valid_q && !resp_hit_q),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif
endmodule
